// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// master drives operands and out_ready; slave is the adder's view.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cIn;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cOut;
    logic             ovf;

    modport master (
        output in_valid, A, B, cIn, sub, out_ready,
        input  in_ready, out_valid, sum, cOut, ovf
    );

    modport slave (
        input  in_valid, A, B, cIn, sub, out_ready,
        output in_ready, out_valid, sum, cOut, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_OVERFLOW_FLAG_EN to build the registered two's-complement overflow flag.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_cla_adder_if.slave   bus
);
    localparam int NG = WIDTH / 4;

    logic             s1Valid_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] p_q;
    logic             c0_q;
    logic             s2Valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cOut_q;

    logic             s2CanLoad;
    logic             s1CanLoad;
    logic             inFire;
    logic [WIDTH-1:0] bEff_d;

    logic [NG-1:0]    groupG;
    logic [NG-1:0]    groupP;
    logic [NG:0]      groupC;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             term;
    logic             acc;

    // A stage may load when empty or when its occupant leaves this same cycle.
    assign s2CanLoad    = !s2Valid_q || bus.out_ready;
    assign s1CanLoad    = !s1Valid_q || s2CanLoad;
    assign bus.in_ready = !rst && s1CanLoad;
    assign inFire       = bus.in_valid && bus.in_ready;
    assign bEff_d       = bus.B ^ {WIDTH{bus.sub}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            g_q       <= '0;
            p_q       <= '0;
            c0_q      <= 1'b0;
        end else if (inFire) begin
            s1Valid_q <= 1'b1;
            g_q       <= bus.A & bEff_d;
            p_q       <= bus.A ^ bEff_d;
            c0_q      <= bus.sub | bus.cIn;
        end else if (s2CanLoad) begin
            s1Valid_q <= 1'b0;
        end
    end

    // Every carry is a flat sum of products of G/P terms, both across groups and within a group.
    always_comb begin
        groupG = '0;
        groupP = '0;
        groupC = '0;
        carry  = '0;
        term   = 1'b0;
        acc    = 1'b0;
        for (int g = 0; g < NG; g++) begin
            groupP[g] = &p_q[4*g +: 4];
            groupG[g] = g_q[4*g+3]
                      | (p_q[4*g+3] & g_q[4*g+2])
                      | (p_q[4*g+3] & p_q[4*g+2] & g_q[4*g+1])
                      | (p_q[4*g+3] & p_q[4*g+2] & p_q[4*g+1] & g_q[4*g]);
        end
        groupC[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            acc = c0_q;
            for (int m = 0; m <= k; m++) acc = acc & groupP[m];
            for (int j = 0; j <= k; j++) begin
                term = groupG[j];
                for (int m = j + 1; m <= k; m++) term = term & groupP[m];
                acc = acc | term;
            end
            groupC[k+1] = acc;
        end
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < 4; i++) begin
                acc = groupC[g];
                for (int m = 0; m < i; m++) acc = acc & p_q[4*g+m];
                for (int j = 0; j < i; j++) begin
                    term = g_q[4*g+j];
                    for (int m = j + 1; m < i; m++) term = term & p_q[4*g+m];
                    acc = acc | term;
                end
                carry[4*g+i] = acc;
            end
        end
        sum_d = p_q ^ carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            sum_q     <= '0;
            cOut_q    <= 1'b0;
        end else if (s2CanLoad) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                sum_q  <= sum_d;
                cOut_q <= groupC[NG];
            end
        end
    end

`ifdef CLA_OVERFLOW_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (s2CanLoad && s1Valid_q) begin
            ovf_q <= carry[WIDTH-1] ^ groupC[NG];
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.out_valid = s2Valid_q;
    assign bus.sum       = sum_q;
    assign bus.cOut      = cOut_q;
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits; legal values: multiples of 4, 4 to 64.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have in_valid, input, 1, operand set on A/B/cIn/sub is valid.
REQ-005 SHALL have in_ready, output, 1, block accepts operands this cycle.
REQ-006 SHALL have A, input, WIDTH, first operand.
REQ-007 SHALL have B, input, WIDTH, second operand.
REQ-008 SHALL have cIn, input, 1, carry-in; ignored when sub=1.
REQ-009 SHALL have sub, input, 1, mode: 0 = A+B+cIn, 1 = A-B (A + ~B + 1).
REQ-010 SHALL have out_valid, output, 1, result on sum/cOut/ovf is valid.
REQ-011 SHALL have out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have sum, output, WIDTH, result bits.
REQ-013 SHALL have cOut, output, 1, carry out of the MSB; for sub it is the not-borrow flag.
REQ-014 SHALL have ovf, output, 1, two's-complement overflow flag (see Configuration).

Function
REQ-015 An input transfer SHALL occur on a clk edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-016 Stage 1 SHALL register the effective operands: A, B' = B xor {WIDTH{sub}}, c0 = sub ? 1 : cIn, plus per-bit G = A & B' and P = A ^ B'.
REQ-017 Stage 2 SHALL compute 4-bit group generate/propagate, derive group carries by lookahead across groups (no ripple between groups), form sum = P ^ carries, and register sum, cOut, ovf.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput SHALL be 1 result per cycle.
REQ-019 Each stage SHALL hold one entry with its own valid bit; a stage SHALL load when empty or when its contents move on in the same cycle.
REQ-020 in_ready SHALL be 1 when stage 1 is empty, or stage 2 is empty, or out_ready is 1; combinational from out_ready only.
REQ-021 While out_valid=1 and out_ready=0, sum/cOut/ovf SHALL hold stable.
REQ-022 A simultaneous input and output transfer SHALL advance both stages with no bubble and no loss.
REQ-023 Results SHALL leave in acceptance order; no transaction is dropped or duplicated.
REQ-024 When no input transfer occurs, stage 1 SHALL clear its valid bit, or keep its entry if it cannot advance.

Reset
REQ-025 Asserting rst SHALL immediately clear both stage valid bits and drive out_valid=0, sum=0, cOut=0, ovf=0.
REQ-026 While rst=1, in_ready SHALL be 0.
REQ-027 In-flight transactions at reset SHALL be discarded; the first input transfer after release SHALL produce the first out_valid.

Configuration
REQ-028 Macro CLA_OVERFLOW_FLAG_EN defined: ovf SHALL equal the carry into the MSB xor cOut, registered with sum.
REQ-029 Macro CLA_OVERFLOW_FLAG_EN undefined: ovf SHALL be tied to 0, no overflow logic is built, and all other behaviour is unchanged.

Verification
REQ-030 WIDTH=16, A=0xFFFF, B=0x0001, cIn=0, sub=0, out_ready=1 -> 2 cycles later: sum=0x0000, cOut=1, ovf=0.
REQ-031 A=0x0005, B=0x0007, sub=1, cIn=1 (ignored) -> sum=0xFFFE, cOut=0; then A=0x0007, B=0x0005 -> sum=0x0002, cOut=1.
REQ-032 With CLA_OVERFLOW_FLAG_EN: A=0x7FFF, B=0x0001, sub=0 -> sum=0x8000, ovf=1, cOut=0. Without the macro, same stimulus -> ovf=0.
REQ-033 out_ready=0, three back-to-back transfers 1+1, 2+2, 3+3 offered -> in_ready drops after two accepts and sum=0x0002 holds stable. Then out_ready=1 -> results 0x0002, 0x0004, 0x0006 in order, none lost.
REQ-034 Assert rst for 1 cycle while two transactions are in flight -> out_valid=0 and sum=0 at once, and no stale result appears. The next accepted 0x1234+0x1111 -> sum=0x2345 after 2 cycles.
REQ-035 WIDTH=64, random operands, continuous in_valid and out_ready -> one result per cycle matching the reference sum, cOut and ovf.
